channel_tee: RTL and testbench

- Splices one local control unit (CU) into a daisy-chained bus-and-tag parallel channel.
- Port "B" faces upstream toward the channel; port "A" faces downstream toward the next CU.
- Outbound bus and tags are fanned out to both the local CU and port A.
- Inbound bus and tags from the local CU and port A are merged onto port B.
- The select-out chain is broken at this point, so the local CU can either intercept selection or propagate it downstream.

---
 rtl/channel_tee.sv | 144 ++++++++++++++
 tb/tb_channel_tee.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_tee.sv
// Tee that splices one local control unit into a daisy-chained bus-and-tag channel:
// B faces upstream, A faces downstream, and select-out is broken through the local CU.
module channel_tee (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] b_bus_out,
   input  logic       b_bus_out_parity,
   input  logic       b_operational_out,
   input  logic       b_hold_out,
   input  logic       b_select_out,
   input  logic       b_address_out,
   input  logic       b_command_out,
   input  logic       b_service_out,
   input  logic       b_suppress_out,
   output logic [7:0] b_bus_in,
   output logic       b_bus_in_parity,
   output logic       b_request_in,
   output logic       b_select_in,
   output logic       b_operational_in,
   output logic       b_address_in,
   output logic       b_status_in,
   output logic       b_service_in,
   output logic [7:0] a_bus_out,
   output logic       a_bus_out_parity,
   output logic       a_operational_out,
   output logic       a_hold_out,
   output logic       a_select_out,
   output logic       a_address_out,
   output logic       a_command_out,
   output logic       a_service_out,
   output logic       a_suppress_out,
   input  logic [7:0] a_bus_in,
   input  logic       a_bus_in_parity,
   input  logic       a_request_in,
   input  logic       a_select_in,
   input  logic       a_operational_in,
   input  logic       a_address_in,
   input  logic       a_status_in,
   input  logic       a_service_in,
   output logic [7:0] bus_out,
   output logic       bus_out_parity,
   output logic       operational_out,
   output logic       hold_out,
   output logic       address_out,
   output logic       command_out,
   output logic       service_out,
   output logic       suppress_out,
   input  logic [7:0] bus_in,
   input  logic       bus_in_parity,
   input  logic       request_in,
   input  logic       operational_in,
   input  logic       address_in,
   input  logic       status_in,
   input  logic       service_in,
   output logic       selection_x,
   input  logic       selection_y
);

   // B word: [15:8] bus, [7] parity, [6] opl, [5] hold, [4] select, [3] addr, [2] cmd, [1] svc, [0] supp
   logic [15:0] b_raw_s;
   logic [15:0] b_s1_q;
   logic [15:0] b_s2_q;
   // A repeat word: B word with the select bit removed
   logic [14:0] a_rep_q;
   // A word: [14:7] bus, [6] parity, [5] req, [4] select, [3] opl, [2] addr, [1] status, [0] svc
   logic [14:0] a_raw_s;
   logic [14:0] a_s1_q;
   logic [14:0] a_s2_q;
   logic [14:0] b_in_d;
   logic [14:0] b_in_q;
   logic        a_sel_d;
   logic        a_sel_q;
   logic        local_active_s;

   assign b_raw_s = {b_bus_out, b_bus_out_parity, b_operational_out, b_hold_out, b_select_out,
                     b_address_out, b_command_out, b_service_out, b_suppress_out};
   assign a_raw_s = {a_bus_in, a_bus_in_parity, a_request_in, a_select_in, a_operational_in,
                     a_address_in, a_status_in, a_service_in};

   // Inbound merge: tags are ORed, select-in comes only from downstream, local CU owns the bus when active
   always_comb begin
      local_active_s = operational_in | address_in | status_in | service_in;
      b_in_d         = 15'd0;
      b_in_d[5:0]    = {request_in | a_s2_q[5], a_s2_q[4], operational_in | a_s2_q[3],
                        address_in | a_s2_q[2], status_in | a_s2_q[1], service_in | a_s2_q[0]};
      if (local_active_s) begin
         b_in_d[14:6] = {bus_in, bus_in_parity};
      end else begin
         b_in_d[14:6] = a_s2_q[14:6];
      end
      a_sel_d = selection_y & b_s2_q[6];
   end

   // Synchronizers and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         b_s1_q  <= 16'd0;
         b_s2_q  <= 16'd0;
         a_rep_q <= 15'd0;
         a_s1_q  <= 15'd0;
         a_s2_q  <= 15'd0;
         b_in_q  <= 15'd0;
         a_sel_q <= 1'b0;
      end else begin
         b_s1_q  <= b_raw_s;
         b_s2_q  <= b_s1_q;
         a_rep_q <= {b_s2_q[15:5], b_s2_q[3:0]};
         a_s1_q  <= a_raw_s;
         a_s2_q  <= a_s1_q;
         b_in_q  <= b_in_d;
         a_sel_q <= a_sel_d;
      end
   end

   assign bus_out         = b_s2_q[15:8];
   assign bus_out_parity  = b_s2_q[7];
   assign operational_out = b_s2_q[6];
   assign hold_out        = b_s2_q[5];
   assign selection_x     = b_s2_q[4];
   assign address_out     = b_s2_q[3];
   assign command_out     = b_s2_q[2];
   assign service_out     = b_s2_q[1];
   assign suppress_out    = b_s2_q[0];

   assign a_bus_out         = a_rep_q[14:7];
   assign a_bus_out_parity  = a_rep_q[6];
   assign a_operational_out = a_rep_q[5];
   assign a_hold_out        = a_rep_q[4];
   assign a_address_out     = a_rep_q[3];
   assign a_command_out     = a_rep_q[2];
   assign a_service_out     = a_rep_q[1];
   assign a_suppress_out    = a_rep_q[0];
   assign a_select_out      = a_sel_q;

   assign b_bus_in         = b_in_q[14:7];
   assign b_bus_in_parity  = b_in_q[6];
   assign b_request_in     = b_in_q[5];
   assign b_select_in      = b_in_q[4];
   assign b_operational_in = b_in_q[3];
   assign b_address_in     = b_in_q[2];
   assign b_status_in      = b_in_q[1];
   assign b_service_in     = b_in_q[0];

endmodule

// File: tb/tb_channel_tee.sv
// Scoreboard bench for channel_tee: stimulus pushes expected values tagged with the cycle
// they must appear; a negedge monitor pops and compares them.
module tb_channel_tee;

   localparam int S_BUS_OUT  = 0;
   localparam int S_BUS_PAR  = 1;
   localparam int S_A_BUS    = 2;
   localparam int S_A_PAR    = 3;
   localparam int S_SELX     = 4;
   localparam int S_A_SEL    = 5;
   localparam int S_B_SEL    = 6;
   localparam int S_B_OP     = 7;
   localparam int S_B_ADDR   = 8;
   localparam int S_B_BUS    = 9;
   localparam int S_B_PAR    = 10;
   localparam int S_B_STAT   = 11;
   localparam int S_B_SVC    = 12;
   localparam int S_B_REQ    = 13;
   localparam int S_ALL_ZERO = 14;

   typedef struct {
      int         cyc;
      int         sig;
      logic [7:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic [7:0] b_bus_out;
   logic b_bus_out_parity, b_operational_out, b_hold_out, b_select_out;
   logic b_address_out, b_command_out, b_service_out, b_suppress_out;
   logic [7:0] b_bus_in;
   logic b_bus_in_parity, b_request_in, b_select_in, b_operational_in;
   logic b_address_in, b_status_in, b_service_in;
   logic [7:0] a_bus_out;
   logic a_bus_out_parity, a_operational_out, a_hold_out, a_select_out;
   logic a_address_out, a_command_out, a_service_out, a_suppress_out;
   logic [7:0] a_bus_in;
   logic a_bus_in_parity, a_request_in, a_select_in, a_operational_in;
   logic a_address_in, a_status_in, a_service_in;
   logic [7:0] bus_out;
   logic bus_out_parity, operational_out, hold_out, address_out;
   logic command_out, service_out, suppress_out;
   logic [7:0] bus_in;
   logic bus_in_parity, request_in, operational_in, address_in, status_in, service_in;
   logic selection_x, selection_y;
   logic loop_en, sel_y_drv;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];

   assign selection_y = loop_en ? selection_x : sel_y_drv;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   channel_tee dut (
      .clk(clk), .reset(reset),
      .b_bus_out(b_bus_out), .b_bus_out_parity(b_bus_out_parity),
      .b_operational_out(b_operational_out), .b_hold_out(b_hold_out),
      .b_select_out(b_select_out), .b_address_out(b_address_out),
      .b_command_out(b_command_out), .b_service_out(b_service_out),
      .b_suppress_out(b_suppress_out),
      .b_bus_in(b_bus_in), .b_bus_in_parity(b_bus_in_parity),
      .b_request_in(b_request_in), .b_select_in(b_select_in),
      .b_operational_in(b_operational_in), .b_address_in(b_address_in),
      .b_status_in(b_status_in), .b_service_in(b_service_in),
      .a_bus_out(a_bus_out), .a_bus_out_parity(a_bus_out_parity),
      .a_operational_out(a_operational_out), .a_hold_out(a_hold_out),
      .a_select_out(a_select_out), .a_address_out(a_address_out),
      .a_command_out(a_command_out), .a_service_out(a_service_out),
      .a_suppress_out(a_suppress_out),
      .a_bus_in(a_bus_in), .a_bus_in_parity(a_bus_in_parity),
      .a_request_in(a_request_in), .a_select_in(a_select_in),
      .a_operational_in(a_operational_in), .a_address_in(a_address_in),
      .a_status_in(a_status_in), .a_service_in(a_service_in),
      .bus_out(bus_out), .bus_out_parity(bus_out_parity),
      .operational_out(operational_out), .hold_out(hold_out),
      .address_out(address_out), .command_out(command_out),
      .service_out(service_out), .suppress_out(suppress_out),
      .bus_in(bus_in), .bus_in_parity(bus_in_parity), .request_in(request_in),
      .operational_in(operational_in), .address_in(address_in),
      .status_in(status_in), .service_in(service_in),
      .selection_x(selection_x), .selection_y(selection_y)
   );

   function automatic logic [7:0] actual(input int sig);
      logic any_s;
      any_s = (|b_bus_in) | b_bus_in_parity | b_request_in | b_select_in | b_operational_in |
              b_address_in | b_status_in | b_service_in | (|a_bus_out) | a_bus_out_parity |
              a_operational_out | a_hold_out | a_select_out | a_address_out | a_command_out |
              a_service_out | a_suppress_out | (|bus_out) | bus_out_parity | operational_out |
              hold_out | address_out | command_out | service_out | suppress_out | selection_x;
      case (sig)
         S_BUS_OUT:  return bus_out;
         S_BUS_PAR:  return {7'd0, bus_out_parity};
         S_A_BUS:    return a_bus_out;
         S_A_PAR:    return {7'd0, a_bus_out_parity};
         S_SELX:     return {7'd0, selection_x};
         S_A_SEL:    return {7'd0, a_select_out};
         S_B_SEL:    return {7'd0, b_select_in};
         S_B_OP:     return {7'd0, b_operational_in};
         S_B_ADDR:   return {7'd0, b_address_in};
         S_B_BUS:    return b_bus_in;
         S_B_PAR:    return {7'd0, b_bus_in_parity};
         S_B_STAT:   return {7'd0, b_status_in};
         S_B_SVC:    return {7'd0, b_service_in};
         S_B_REQ:    return {7'd0, b_request_in};
         S_ALL_ZERO: return {7'd0, any_s};
         default:    return 8'hxx;
      endcase
   endfunction

   function automatic string sig_name(input int sig);
      case (sig)
         S_BUS_OUT:  return "bus_out";
         S_BUS_PAR:  return "bus_out_parity";
         S_A_BUS:    return "a_bus_out";
         S_A_PAR:    return "a_bus_out_parity";
         S_SELX:     return "selection_x";
         S_A_SEL:    return "a_select_out";
         S_B_SEL:    return "b_select_in";
         S_B_OP:     return "b_operational_in";
         S_B_ADDR:   return "b_address_in";
         S_B_BUS:    return "b_bus_in";
         S_B_PAR:    return "b_bus_in_parity";
         S_B_STAT:   return "b_status_in";
         S_B_SVC:    return "b_service_in";
         S_B_REQ:    return "b_request_in";
         S_ALL_ZERO: return "any_output_during_reset";
         default:    return "unknown";
      endcase
   endfunction

   // Monitor: compare every expectation due in the current cycle
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            logic [7:0] act;
            act = actual(sb[i].sig);
            checks++;
            if (act !== sb[i].val) begin
               failures++;
               $display("FAIL %s cycle %0d: got %h expected %h",
                        sig_name(sb[i].sig), cyc, act, sb[i].val);
            end
            sb.delete(i);
         end
      end
   end

   task automatic push(input int dly, input int sig, input logic [7:0] val);
      exp_t e;
      e.cyc = cyc + dly;
      e.sig = sig;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset = 1'b0;
      {b_bus_out, b_bus_out_parity, b_operational_out, b_hold_out, b_select_out} = 12'd0;
      {b_address_out, b_command_out, b_service_out, b_suppress_out} = 4'd0;
      {a_bus_in, a_bus_in_parity, a_request_in, a_select_in, a_operational_in} = 12'd0;
      {a_address_in, a_status_in, a_service_in} = 3'd0;
      {bus_in, bus_in_parity, request_in, operational_in} = 11'd0;
      {address_in, status_in, service_in} = 3'd0;
      loop_en = 1'b0;
      sel_y_drv = 1'b0;
      step(2);
      push(0, S_ALL_ZERO, 8'h00);
      step(1);
      reset = 1'b1;
      step(2);

      // bus 0x5A: 2 clocks to local, 3 clocks to A
      b_bus_out = 8'h5A;
      b_bus_out_parity = 1'b1;
      push(1, S_BUS_OUT, 8'h00);
      push(2, S_BUS_OUT, 8'h5A);
      push(2, S_BUS_PAR, 8'h01);
      push(2, S_A_BUS, 8'h00);
      push(3, S_A_BUS, 8'h5A);
      push(3, S_A_PAR, 8'h01);
      step(4);

      // Reset mid-traffic, with local and A inputs also active
      request_in = 1'b1;
      a_status_in = 1'b1;
      step(4);
      reset = 1'b0;
      #1;
      push(0, S_ALL_ZERO, 8'h00);
      step(2);
      reset = 1'b1;
      request_in = 1'b0;
      a_status_in = 1'b0;
      push(2, S_BUS_OUT, 8'h5A);
      push(3, S_A_BUS, 8'h5A);
      step(4);

      // Selection pass-through with local loop
      b_operational_out = 1'b1;
      b_select_out = 1'b1;
      loop_en = 1'b1;
      push(2, S_SELX, 8'h01);
      push(2, S_A_SEL, 8'h00);
      push(3, S_A_SEL, 8'h01);
      step(4);
      a_select_in = 1'b1;
      push(2, S_B_SEL, 8'h00);
      push(3, S_B_SEL, 8'h01);
      step(4);
      b_operational_out = 1'b0;
      a_select_in = 1'b0;
      push(2, S_A_SEL, 8'h01);
      push(3, S_A_SEL, 8'h00);
      push(3, S_B_SEL, 8'h00);
      push(3, S_SELX, 8'h01);
      step(4);

      // Interception: local CU holds selection and takes the bus
      b_operational_out = 1'b1;
      loop_en = 1'b0;
      sel_y_drv = 1'b0;
      step(4);
      operational_in = 1'b1;
      address_in = 1'b1;
      bus_in = 8'hFF;
      bus_in_parity = 1'b1;
      push(1, S_B_OP, 8'h01);
      push(1, S_B_ADDR, 8'h01);
      push(1, S_B_BUS, 8'hFF);
      push(1, S_B_PAR, 8'h01);
      push(1, S_A_SEL, 8'h00);
      push(1, S_SELX, 8'h01);
      step(3);
      {bus_in, bus_in_parity, operational_in, address_in} = 10'd0;
      push(1, S_B_BUS, 8'h00);
      push(1, S_B_OP, 8'h00);
      step(3);

      // Downstream status with local idle
      a_status_in = 1'b1;
      a_bus_in = 8'h0C;
      a_bus_in_parity = 1'b1;
      push(2, S_B_STAT, 8'h00);
      push(3, S_B_STAT, 8'h01);
      push(3, S_B_BUS, 8'h0C);
      push(3, S_B_PAR, 8'h01);
      step(4);
      {a_status_in, a_bus_in, a_bus_in_parity} = 10'd0;
      step(4);

      // Contention: local service wins the bus over A
      service_in = 1'b1;
      bus_in = 8'h01;
      bus_in_parity = 1'b0;
      a_service_in = 1'b1;
      a_bus_in = 8'h22;
      a_bus_in_parity = 1'b1;
      push(1, S_B_BUS, 8'h01);
      push(1, S_B_SVC, 8'h01);
      push(4, S_B_BUS, 8'h01);
      push(4, S_B_SVC, 8'h01);
      push(4, S_B_PAR, 8'h00);
      step(5);
      service_in = 1'b0;
      push(1, S_B_BUS, 8'h22);
      push(1, S_B_PAR, 8'h01);
      push(1, S_B_SVC, 8'h01);
      step(3);
      {a_service_in, a_bus_in, a_bus_in_parity, bus_in} = 18'd0;
      step(4);

      // Request OR from either side
      a_request_in = 1'b1;
      push(2, S_B_REQ, 8'h00);
      push(3, S_B_REQ, 8'h01);
      step(4);
      a_request_in = 1'b0;
      request_in = 1'b1;
      push(1, S_B_REQ, 8'h01);
      push(4, S_B_REQ, 8'h01);
      step(5);
      request_in = 1'b0;
      push(1, S_B_REQ, 8'h00);
      step(3);

      // Bounded drain of the scoreboard
      for (int i = 0; i < 20 && sb.size() != 0; i++) step(1);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
